rate_tick_gen: RTL

- Consumer end of the speed-control interface: takes the 32-bit divider count produced by speed_control and turns it into a periodic sample-rate tick plus a square-wave sample clock.
- Sits between speed_control and the audio sample fetcher; delivers each tick over a req/ack handshake and counts missed ticks.
- Period changes from speed_up/speed_down take effect only at a period boundary, so the sample clock never glitches.

---
 rtl/speed_pkg.sv | 26 ++
 rtl/tick_handshake.sv | 78 +++++++
 rtl/rate_tick_gen.sv | 100 ++++++++++
 3 files changed

// File: rtl/speed_pkg.sv
// Shared definitions for the speed-control path.
//
// Holds the divider width, the clamp floor, the reset period and the
// handshake state encoding used by rate_tick_gen / tick_handshake.
// speed_control imports COUNT_W and DEFAULT_COUNT from here, so the
// producer and consumer of clk_count always agree on width and reset rate.
package speed_pkg;

    // Width of the divider count handed from speed_control to the tick generator.
    localparam int COUNT_W       = 32;

    // Shortest period the tick generator will run. One-cycle and zero-cycle
    // requests are clamped up to this so the sample clock keeps both phases.
    localparam int MIN_COUNT     = 2;

    // Period used out of reset (roughly 44.1 kHz from a 50 MHz clock).
    localparam int DEFAULT_COUNT = 1136;

    // Tick delivery state: IDLE means no tick outstanding, PEND means
    // tick_req is raised and waiting for tick_ack.
    typedef enum logic [0:0] {
        HS_IDLE = 1'b0,
        HS_PEND = 1'b1
    } hs_state_t;

endpackage : speed_pkg

// File: rtl/tick_handshake.sv
// Tick delivery state machine with a saturating overrun counter.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-low reset
//   terminal_i    in   one-cycle strobe: the divider is in its last cycle
//   tick_ack_i    in   downstream accepts the pending tick
//   state_o       out  current handshake state (tick_req is state == HS_PEND)
//   overrun_cnt_o out  ticks generated while the previous one was still
//                      pending, saturating at all-ones
//
// Handshake: tick_req (derived from state_o) rises on the edge after a
// terminal cycle and stays high until an edge where tick_ack is 1. A tick
// is transferred on every edge with tick_req=1 and tick_ack=1. tick_ack is
// ignored while no tick is pending.
module tick_handshake
    import speed_pkg::*;
#(
    parameter int OVR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             terminal_i,
    input  logic             tick_ack_i,
    output hs_state_t        state_o,
    output logic [OVR_W-1:0] overrun_cnt_o
);

    hs_state_t        state_q;
    hs_state_t        state_d;
    logic [OVR_W-1:0] ovr_q;
    logic [OVR_W-1:0] ovr_d;

    always_comb begin
        state_d = state_q;
        ovr_d   = ovr_q;

        case (state_q)
            HS_IDLE: begin
                if (terminal_i) begin
                    state_d = HS_PEND;
                end
            end

            HS_PEND: begin
                if (terminal_i) begin
                    // A new tick arrives while one is outstanding. With an ack
                    // on the same edge the old tick is consumed and the new
                    // one simply takes its place; without an ack it is lost.
                    state_d = HS_PEND;
                    if (!tick_ack_i && (ovr_q != {OVR_W{1'b1}})) begin
                        ovr_d = ovr_q + OVR_W'(1);
                    end
                end else if (tick_ack_i) begin
                    state_d = HS_IDLE;
                end
            end

            default: begin
                state_d = HS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= HS_IDLE;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            ovr_q   <= ovr_d;
        end
    end

    assign state_o       = state_q;
    assign overrun_cnt_o = ovr_q;

endmodule : tick_handshake

// File: rtl/rate_tick_gen.sv
// Sample-rate tick generator fed by speed_control.
//
// Divides clk by a period taken from clk_count, producing a periodic tick
// delivered over a req/ack handshake and a square-wave sample clock. New
// periods are only picked up at the end of the running period, so
// sample_clk never has a short phase.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-low reset
//   enable        in   1 = count, 0 = freeze counter, period and sample_clk
//   clk_count     in   requested period in clk cycles
//   tick_ack      in   downstream accepts the pending tick
//   tick_req      out  tick pending, held until acknowledged
//   sample_clk    out  toggles once per period
//   period_active out  period currently being counted
//   overrun_cnt   out  ticks dropped while tick_req was pending (saturating)
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
module rate_tick_gen #(
    parameter int COUNT_W       = speed_pkg::COUNT_W,
    parameter int MIN_COUNT     = speed_pkg::MIN_COUNT,
    parameter int DEFAULT_COUNT = speed_pkg::DEFAULT_COUNT,
    parameter int OVR_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [COUNT_W-1:0] clk_count,
    input  logic               tick_ack,
    output logic               tick_req,
    output logic               sample_clk,
    output logic [COUNT_W-1:0] period_active,
    output logic [OVR_W-1:0]   overrun_cnt
);

    localparam logic [COUNT_W-1:0] MIN_PERIOD     = COUNT_W'(MIN_COUNT);
    localparam logic [COUNT_W-1:0] DEFAULT_PERIOD = COUNT_W'(DEFAULT_COUNT);

    logic [COUNT_W-1:0]   cnt_q;
    logic [COUNT_W-1:0]   cnt_d;
    logic [COUNT_W-1:0]   period_q;
    logic [COUNT_W-1:0]   period_d;
    logic                 sample_clk_q;
    logic                 sample_clk_d;

    logic [COUNT_W-1:0]   period_req;
    logic                 terminal;
    speed_pkg::hs_state_t hs_state;

    always_comb begin
        cnt_d        = cnt_q;
        period_d     = period_q;
        sample_clk_d = sample_clk_q;

        // Clamp the requested period; only used on the terminal edge.
        period_req = (clk_count < MIN_PERIOD) ? MIN_PERIOD : clk_count;

        // period_q is never below MIN_PERIOD (>= 2), so the subtraction
        // cannot wrap and cnt_q stays strictly below period_q.
        terminal = enable && (cnt_q == (period_q - COUNT_W'(1)));

        if (terminal) begin
            cnt_d        = '0;
            period_d     = period_req;
            sample_clk_d = ~sample_clk_q;
        end else if (enable) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q        <= '0;
            period_q     <= DEFAULT_PERIOD;
            sample_clk_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            sample_clk_q <= sample_clk_d;
        end
    end

    tick_handshake #(
        .OVR_W (OVR_W)
    ) u_tick_handshake (
        .clk           (clk),
        .reset         (reset),
        .terminal_i    (terminal),
        .tick_ack_i    (tick_ack),
        .state_o       (hs_state),
        .overrun_cnt_o (overrun_cnt)
    );

    assign tick_req      = (hs_state == speed_pkg::HS_PEND);
    assign sample_clk    = sample_clk_q;
    assign period_active = period_q;

endmodule : rate_tick_gen
